// File: rtl/sal_sched_pkg.sv
// sal_sched_pkg: shared command and arbitration class encodings for the bank schedulers
package sal_sched_pkg;
  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;
  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_COL  = 3'd1,
    CLS_ACT  = 3'd2,
    CLS_MNT  = 3'd3,
    CLS_ALL  = 3'd4
  } cls_t;
endpackage

// File: rtl/sal_rr_arbiter.sv
// sal_rr_arbiter: round-robin pick of the first requester at or after ptr
module sal_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);
  localparam int W = $clog2(N);
  logic [W-1:0] j;
  // scan offsets from farthest to nearest so the nearest requester to ptr wins last
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = ptr + W'(i);
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/sal_cmd_arbiter.sv
// sal_cmd_arbiter: grants one timing-legal bank command per cycle and registers it toward DFI
module sal_cmd_arbiter
  import sal_sched_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int RA_W      = 16,
  parameter int CA_W      = 10,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 4,
  parameter int TCNT_W    = 4,
  parameter bit COL_FIRST = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [TCNT_W-1:0]              t_rrd_m1,
  input  logic [TCNT_W-1:0]              t_ccd_m1,
  input  logic [TCNT_W-1:0]              t_wtr_m1,
  input  logic [TCNT_W-1:0]              t_rtw_m1,
  input  logic [NUM_BANKS-1:0]           act_req,
  input  logic [NUM_BANKS-1:0]           rd_req,
  input  logic [NUM_BANKS-1:0]           wr_req,
  input  logic [NUM_BANKS-1:0]           pre_req,
  input  logic [NUM_BANKS-1:0]           ref_req,
  input  logic [NUM_BANKS*RA_W-1:0]      ra,
  input  logic [NUM_BANKS*CA_W-1:0]      ca,
  input  logic [NUM_BANKS*ID_W-1:0]      id,
  input  logic [NUM_BANKS*LEN_W-1:0]     len,
  output logic [NUM_BANKS-1:0]           act_gnt,
  output logic [NUM_BANKS-1:0]           rd_gnt,
  output logic [NUM_BANKS-1:0]           wr_gnt,
  output logic [NUM_BANKS-1:0]           pre_gnt,
  output logic [NUM_BANKS-1:0]           ref_gnt,
  output logic                           cmd_valid,
  output cmd_t                           cmd,
  output logic [$clog2(NUM_BANKS)-1:0]   cmd_ba,
  output logic [RA_W-1:0]                cmd_ra,
  output logic [CA_W-1:0]                cmd_ca,
  output logic [ID_W-1:0]                cmd_id,
  output logic [LEN_W-1:0]               cmd_len
);
  localparam int BA_W = $clog2(NUM_BANKS);
  logic [TCNT_W-1:0] rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
  logic [BA_W-1:0] rr_ptr;
  logic [NUM_BANKS-1:0] act_e, rd_e, wr_e, col_e, mnt_e, all_e;
  logic [NUM_BANKS-1:0] col_g, act_g, mnt_g, all_g, gnt;
  logic [BA_W-1:0] col_i, act_i, mnt_i, all_i, sel;
  cls_t cls;
  cmd_t sel_cmd;
  // mask each request class by the inter-bank timing counters that gate it
  always_comb begin
    act_e = rrd_cnt == '0 ? act_req : '0;
    rd_e = (ccd_cnt == '0 && wtr_cnt == '0) ? rd_req : '0;
    wr_e = (ccd_cnt == '0 && rtw_cnt == '0) ? wr_req : '0;
    col_e = rd_e | wr_e;
    mnt_e = pre_req | ref_req;
    all_e = col_e | act_e | mnt_e;
  end
  sal_rr_arbiter #(.N(NUM_BANKS)) u_col (.req(col_e), .ptr(rr_ptr), .gnt(col_g), .idx(col_i));
  sal_rr_arbiter #(.N(NUM_BANKS)) u_act (.req(act_e), .ptr(rr_ptr), .gnt(act_g), .idx(act_i));
  sal_rr_arbiter #(.N(NUM_BANKS)) u_mnt (.req(mnt_e), .ptr(rr_ptr), .gnt(mnt_g), .idx(mnt_i));
  sal_rr_arbiter #(.N(NUM_BANKS)) u_all (.req(all_e), .ptr(rr_ptr), .gnt(all_g), .idx(all_i));
  // pick the winning class, then the bank and command type it carries; nothing granted in reset
  always_comb begin
    cls = !rst_n ? CLS_NONE :
          !COL_FIRST ? (|all_e ? CLS_ALL : CLS_NONE) :
          |col_e ? CLS_COL : |act_e ? CLS_ACT : |mnt_e ? CLS_MNT : CLS_NONE;
    gnt = cls == CLS_ALL ? all_g : cls == CLS_COL ? col_g :
          cls == CLS_ACT ? act_g : cls == CLS_MNT ? mnt_g : '0;
    sel = cls == CLS_ALL ? all_i : cls == CLS_COL ? col_i :
          cls == CLS_ACT ? act_i : cls == CLS_MNT ? mnt_i : '0;
    sel_cmd = ~|gnt ? CMD_NOP : rd_e[sel] ? CMD_RD : wr_e[sel] ? CMD_WR :
              act_e[sel] ? CMD_ACT : pre_req[sel] ? CMD_PRE : CMD_REF;
  end
  assign act_gnt = gnt & act_e;
  assign rd_gnt  = gnt & rd_e;
  assign wr_gnt  = gnt & wr_e;
  assign pre_gnt = gnt & pre_req;
  assign ref_gnt = gnt & ref_req;
  // timing counters: load on the relevant grant (load beats decrement), else count down to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrd_cnt <= '0;
      ccd_cnt <= '0;
      wtr_cnt <= '0;
      rtw_cnt <= '0;
    end else begin
      rrd_cnt <= sel_cmd == CMD_ACT ? t_rrd_m1 : rrd_cnt == '0 ? '0 : rrd_cnt - TCNT_W'(1);
      ccd_cnt <= (sel_cmd == CMD_RD || sel_cmd == CMD_WR) ? t_ccd_m1 :
                 ccd_cnt == '0 ? '0 : ccd_cnt - TCNT_W'(1);
      wtr_cnt <= sel_cmd == CMD_WR ? t_wtr_m1 : wtr_cnt == '0 ? '0 : wtr_cnt - TCNT_W'(1);
      rtw_cnt <= sel_cmd == CMD_RD ? t_rtw_m1 : rtw_cnt == '0 ? '0 : rtw_cnt - TCNT_W'(1);
    end
  end
  // register the granted command; fields and pointer only move on a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd <= CMD_NOP;
      cmd_ba <= '0;
      cmd_ra <= '0;
      cmd_ca <= '0;
      cmd_id <= '0;
      cmd_len <= '0;
      rr_ptr <= '0;
    end else begin
      cmd_valid <= |gnt;
      cmd <= sel_cmd;
      if (|gnt) begin
        cmd_ba <= sel;
        cmd_ra <= ra[sel*RA_W +: RA_W];
        cmd_ca <= ca[sel*CA_W +: CA_W];
        cmd_id <= id[sel*ID_W +: ID_W];
        cmd_len <= len[sel*LEN_W +: LEN_W];
        rr_ptr <= sel + BA_W'(1);
      end
    end
  end
  genvar g;
  for (g = 0; g < NUM_BANKS; g++) begin : g_req_chk
    a_one_req_type: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({act_req[g], rd_req[g], wr_req[g], pre_req[g], ref_req[g]}));
  end
endmodule

// File: tb/tb_sal_cmd_arbiter.sv
// tb_sal_cmd_arbiter: directed scenario checks of the multi-bank command arbiter
module tb_sal_cmd_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
  logic [3:0] act_req, rd_req, wr_req, pre_req, ref_req;
  logic [63:0] ra;
  logic [39:0] ca;
  logic [15:0] id, len;
  logic [3:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic cmd_valid;
  logic [2:0] cmd;
  logic [1:0] cmd_ba;
  logic [15:0] cmd_ra;
  logic [9:0] cmd_ca;
  logic [3:0] cmd_id, cmd_len;
  logic [3:0] b_act_gnt, b_rd_gnt, b_wr_gnt, b_pre_gnt, b_ref_gnt;
  logic b_cmd_valid;
  logic [2:0] b_cmd;
  logic [1:0] b_cmd_ba;
  logic [15:0] b_cmd_ra;
  logic [9:0] b_cmd_ca;
  logic [3:0] b_cmd_id, b_cmd_len;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sal_cmd_arbiter #(.COL_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
    .ra(ra), .ca(ca), .id(id), .len(len),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ba(cmd_ba), .cmd_ra(cmd_ra), .cmd_ca(cmd_ca),
    .cmd_id(cmd_id), .cmd_len(cmd_len)
  );

  sal_cmd_arbiter #(.COL_FIRST(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
    .ra(ra), .ca(ca), .id(id), .len(len),
    .act_gnt(b_act_gnt), .rd_gnt(b_rd_gnt), .wr_gnt(b_wr_gnt), .pre_gnt(b_pre_gnt), .ref_gnt(b_ref_gnt),
    .cmd_valid(b_cmd_valid), .cmd(b_cmd), .cmd_ba(b_cmd_ba), .cmd_ra(b_cmd_ra), .cmd_ca(b_cmd_ca),
    .cmd_id(b_cmd_id), .cmd_len(b_cmd_len)
  );

  task automatic clr;
    act_req = '0;
    rd_req = '0;
    wr_req = '0;
    pre_req = '0;
    ref_req = '0;
    t_rrd_m1 = '0;
    t_ccd_m1 = '0;
    t_wtr_m1 = '0;
    t_rtw_m1 = '0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clr();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    clr();
    act_req = 4'b0001;
    #3;
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b exp 0", cmd_valid); end
    total++; if (cmd !== 3'd0) begin bad++; $display("FAIL reset_cmd got %0d exp 0", cmd); end
    total++; if (cmd_ra !== 16'h0 || cmd_ba !== 2'd0) begin bad++; $display("FAIL reset_fields got ra=%h ba=%0d exp 0", cmd_ra, cmd_ba); end
    total++; if (act_gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got %b exp 0000", act_gnt); end
  endtask

  task automatic test_ccd;
    do_reset();
    t_ccd_m1 = 4'd3;
    for (int c = 0; c < 6; c++) begin
      rd_req = c < 5 ? 4'b0001 : 4'b0000;
      #3;
      total++; if (rd_gnt !== ((c == 0 || c == 4) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL ccd_gnt c=%0d got %b", c, rd_gnt); end
      total++; if (cmd_valid !== (c == 1 || c == 5)) begin bad++; $display("FAIL ccd_valid c=%0d got %0b", c, cmd_valid); end
      if (c == 5) begin
        total++; if (cmd !== 3'd2) begin bad++; $display("FAIL ccd_cmd got %0d exp 2", cmd); end
      end
      step();
    end
  endtask

  task automatic test_rrd;
    do_reset();
    t_rrd_m1 = 4'd1;
    act_req = 4'b0011;
    #3;
    total++; if (act_gnt !== 4'b0001) begin bad++; $display("FAIL rrd_gnt0 got %b exp 0001", act_gnt); end
    step();
    act_req = 4'b0010;
    #3;
    total++; if (act_gnt !== 4'b0000) begin bad++; $display("FAIL rrd_block got %b exp 0000", act_gnt); end
    total++; if (cmd_valid !== 1'b1 || cmd !== 3'd1 || cmd_ba !== 2'd0) begin bad++; $display("FAIL rrd_cmd0 got v=%0b c=%0d ba=%0d exp 1 1 0", cmd_valid, cmd, cmd_ba); end
    total++; if (cmd_ra !== 16'hA000) begin bad++; $display("FAIL rrd_ra0 got %h exp a000", cmd_ra); end
    step();
    #3;
    total++; if (act_gnt !== 4'b0010) begin bad++; $display("FAIL rrd_gnt1 got %b exp 0010", act_gnt); end
    step();
    act_req = 4'b0000;
    #3;
    total++; if (cmd_ba !== 2'd1 || cmd_ra !== 16'hA001 || cmd_len !== 4'd2) begin bad++; $display("FAIL rrd_cmd1 got ba=%0d ra=%h len=%0d exp 1 a001 2", cmd_ba, cmd_ra, cmd_len); end
    step();
    pre_req = 4'b1001;
    #3;
    total++; if (pre_gnt !== 4'b1000) begin bad++; $display("FAIL rrd_ptr got %b exp 1000", pre_gnt); end
  endtask

  task automatic test_col_first;
    do_reset();
    act_req = 4'b0001;
    rd_req = 4'b0100;
    #3;
    total++; if (rd_gnt !== 4'b0100 || act_gnt !== 4'b0000) begin bad++; $display("FAIL colfirst_gnt got rd=%b act=%b exp 0100 0000", rd_gnt, act_gnt); end
    total++; if (b_act_gnt !== 4'b0001 || b_rd_gnt !== 4'b0000) begin bad++; $display("FAIL rrmode_gnt got act=%b rd=%b exp 0001 0000", b_act_gnt, b_rd_gnt); end
    step();
    rd_req = 4'b0000;
    #3;
    total++; if (act_gnt !== 4'b0001) begin bad++; $display("FAIL colfirst_act got %b exp 0001", act_gnt); end
    total++; if (cmd !== 3'd2 || cmd_ba !== 2'd2 || cmd_ca !== 10'h102) begin bad++; $display("FAIL colfirst_cmd got c=%0d ba=%0d ca=%h exp 2 2 102", cmd, cmd_ba, cmd_ca); end
    step();
    act_req = 4'b0000;
    #3;
    total++; if (cmd !== 3'd1 || cmd_ba !== 2'd0) begin bad++; $display("FAIL colfirst_cmd2 got c=%0d ba=%0d exp 1 0", cmd, cmd_ba); end
  endtask

  task automatic test_wtr;
    do_reset();
    t_wtr_m1 = 4'd5;
    for (int c = 0; c < 8; c++) begin
      wr_req = c == 0 ? 4'b0010 : 4'b0000;
      rd_req = (c >= 1 && c <= 6) ? 4'b0010 : 4'b0000;
      #3;
      if (c == 0) begin
        total++; if (wr_gnt !== 4'b0010) begin bad++; $display("FAIL wtr_wr got %b exp 0010", wr_gnt); end
      end
      total++; if (rd_gnt !== (c == 6 ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL wtr_rd c=%0d got %b", c, rd_gnt); end
      if (c == 7) begin
        total++; if (cmd_valid !== 1'b1 || cmd !== 3'd2 || cmd_id !== 4'd6) begin bad++; $display("FAIL wtr_cmd got v=%0b c=%0d id=%0d exp 1 2 6", cmd_valid, cmd, cmd_id); end
      end
      step();
    end
  endtask

  task automatic test_rtw;
    do_reset();
    t_rtw_m1 = 4'd2;
    rd_req = 4'b0010;
    #3;
    total++; if (rd_gnt !== 4'b0010) begin bad++; $display("FAIL rtw_rd got %b exp 0010", rd_gnt); end
    step();
    rd_req = 4'b0000;
    wr_req = 4'b0010;
    ref_req = 4'b1000;
    #3;
    total++; if (ref_gnt !== 4'b1000 || wr_gnt !== 4'b0000) begin bad++; $display("FAIL rtw_ref got ref=%b wr=%b exp 1000 0000", ref_gnt, wr_gnt); end
    step();
    ref_req = 4'b0000;
    #3;
    total++; if (wr_gnt !== 4'b0000) begin bad++; $display("FAIL rtw_block got %b exp 0000", wr_gnt); end
    total++; if (cmd !== 3'd5 || cmd_ba !== 2'd3) begin bad++; $display("FAIL rtw_refcmd got c=%0d ba=%0d exp 5 3", cmd, cmd_ba); end
    step();
    #3;
    total++; if (wr_gnt !== 4'b0010) begin bad++; $display("FAIL rtw_wr got %b exp 0010", wr_gnt); end
    step();
    wr_req = 4'b0000;
    #3;
    total++; if (cmd !== 3'd3 || cmd_valid !== 1'b1) begin bad++; $display("FAIL rtw_cmd got c=%0d v=%0b exp 3 1", cmd, cmd_valid); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] e;
    do_reset();
    rd_req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      e = 4'b0001 << (c % 4);
      #3;
      total++; if (rd_gnt !== e) begin bad++; $display("FAIL b2b_gnt c=%0d got %b exp %b", c, rd_gnt, e); end
      step();
    end
    rd_req = 4'b0000;
    #3;
    total++; if (cmd_valid !== 1'b1 || cmd_ba !== 2'd0) begin bad++; $display("FAIL b2b_last got v=%0b ba=%0d exp 1 0", cmd_valid, cmd_ba); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    t_rrd_m1 = 4'd3;
    act_req = 4'b0001;
    #3;
    total++; if (act_gnt !== 4'b0001) begin bad++; $display("FAIL rstmid_gnt0 got %b exp 0001", act_gnt); end
    step();
    act_req = 4'b0010;
    #3;
    total++; if (act_gnt !== 4'b0000) begin bad++; $display("FAIL rstmid_block got %b exp 0000", act_gnt); end
    step();
    rst_n = 1'b0;
    #3;
    total++; if (cmd_valid !== 1'b0 || cmd_ra !== 16'h0 || act_gnt !== 4'b0000) begin bad++; $display("FAIL rstmid_clear got v=%0b ra=%h gnt=%b exp 0 0 0000", cmd_valid, cmd_ra, act_gnt); end
    step();
    rst_n = 1'b1;
    #3;
    total++; if (act_gnt !== 4'b0010) begin bad++; $display("FAIL rstmid_release got %b exp 0010", act_gnt); end
    step();
    act_req = 4'b0000;
    #3;
    total++; if (cmd_valid !== 1'b1 || cmd !== 3'd1 || cmd_ba !== 2'd1) begin bad++; $display("FAIL rstmid_cmd got v=%0b c=%0d ba=%0d exp 1 1 1", cmd_valid, cmd, cmd_ba); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ra[i*16 +: 16] = 16'hA000 + 16'(i);
      ca[i*10 +: 10] = 10'h100 + 10'(i);
      id[i*4 +: 4] = 4'(i + 5);
      len[i*4 +: 4] = 4'(i + 1);
    end
    test_reset();
    test_ccd();
    test_rrd();
    test_col_first();
    test_wtr();
    test_rtw();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
